io_entrada_teclado: RTL and testbench



---
 rtl/io_entrada_teclado.sv | 178 +++++++++++++++++
 tb/tb_io_entrada_teclado.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_entrada_teclado.sv
// Keypad front end for the CPU IN path: synchronizes and debounces the button and switches,
// assembles decimal digits and hands the value over with valid/ack. Option: IO_AUTO_COMMIT_EN.
module io_entrada_teclado #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_W          = 32,
    parameter int MAX_DIGITS      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_raw,
    input  logic [3:0]        sw_raw,
    input  logic              req,
    input  logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              overflow,
    output logic              bad_key,
    output logic [3:0]        dig_uni,
    output logic [3:0]        dig_dez,
    output logic [3:0]        dig_cen,
    output logic              press_pulse,
    output logic [1:0]        dbg_state
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    // Handshake: data_valid rises when a value is committed and holds, with data_out
    // stable, until a single-cycle ack is seen; data_valid then falls the next cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              state_q;
    logic                btn_meta_q, btn_sync_q, btn_clean_q, btn_clean_dly_q;
    logic [3:0]          sw_meta_q, sw_sync_q;
    logic [DEB_W-1:0]    deb_cnt_q;
    logic                press_q, bad_q, valid_q, busy_q, over_q;
    logic [DATA_W-1:0]   acc_q, acc_d, data_q;
    logic [CNT_W-1:0]    count_q;
    logic [3:0]          dig_uni_q, dig_dez_q, dig_cen_q;
    logic                key_digit, key_enter, key_clear, key_bad;

    always_comb begin
        key_digit = (sw_sync_q <= 4'd9);
        key_enter = (sw_sync_q == 4'hF);
        key_clear = (sw_sync_q == 4'hE);
        key_bad   = (sw_sync_q >= 4'd10) && (sw_sync_q <= 4'd13);
        acc_d     = (acc_q << 3) + (acc_q << 1) + DATA_W'(sw_sync_q);
    end

    // Synchronizers, debounce and press edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q      <= 1'b0;
            btn_sync_q      <= 1'b0;
            sw_meta_q       <= 4'd0;
            sw_sync_q       <= 4'd0;
            deb_cnt_q       <= '0;
            btn_clean_q     <= 1'b0;
            btn_clean_dly_q <= 1'b0;
            press_q         <= 1'b0;
        end else begin
            btn_meta_q      <= btn_raw;
            btn_sync_q      <= btn_meta_q;
            sw_meta_q       <= sw_raw;
            sw_sync_q       <= sw_meta_q;
            btn_clean_dly_q <= btn_clean_q;
            press_q         <= btn_clean_q & ~btn_clean_dly_q;
            if (btn_sync_q == btn_clean_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_clean_q <= btn_sync_q;
                deb_cnt_q   <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
            bad_q     <= 1'b0;
            dig_uni_q <= 4'd0;
            dig_dez_q <= 4'd0;
            dig_cen_q <= 4'd0;
        end else begin
            bad_q <= press_q & key_bad;
            case (state_q)
                ST_IDLE: begin
                    // A press arriving with req is ignored; collection starts clean.
                    if (req) begin
                        state_q   <= ST_COLLECT;
                        busy_q    <= 1'b1;
                        acc_q     <= '0;
                        count_q   <= '0;
                        over_q    <= 1'b0;
                        dig_uni_q <= 4'd0;
                        dig_dez_q <= 4'd0;
                        dig_cen_q <= 4'd0;
                    end
                end
                ST_COLLECT: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        acc_q   <= '0;
                    end else if (press_q) begin
                        if (key_digit) begin
                            if (count_q < CNT_W'(MAX_DIGITS)) begin
                                acc_q     <= acc_d;
                                count_q   <= count_q + 1'b1;
                                dig_cen_q <= dig_dez_q;
                                dig_dez_q <= dig_uni_q;
                                dig_uni_q <= sw_sync_q;
`ifdef IO_AUTO_COMMIT_EN
                                if (count_q == CNT_W'(MAX_DIGITS - 1)) begin
                                    data_q  <= acc_d;
                                    valid_q <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= ST_DONE;
                                end
`endif
                            end else begin
                                over_q <= 1'b1;
                            end
                        end else if (key_clear) begin
                            acc_q     <= '0;
                            count_q   <= '0;
                            over_q    <= 1'b0;
                            dig_uni_q <= 4'd0;
                            dig_dez_q <= 4'd0;
                            dig_cen_q <= 4'd0;
                        end else if (key_enter) begin
                            data_q  <= acc_q;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign busy        = busy_q;
    assign overflow    = over_q;
    assign bad_key     = bad_q;
    assign dig_uni     = dig_uni_q;
    assign dig_dez     = dig_dez_q;
    assign dig_cen     = dig_cen_q;
    assign press_pulse = press_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_io_entrada_teclado.sv
// Self-checking bench for io_entrada_teclado: debounce timing, digit entry, handshake and reset,
// with random key sequences checked against a decimal-list reference model.
module tb_io_entrada_teclado;

    localparam int DEB  = 4;
    localparam int W    = 32;
    localparam int MAXD = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         btn_raw = 1'b0;
    logic [3:0]   sw_raw = 4'd0;
    logic         req = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid, busy, overflow, bad_key, press_pulse;
    logic [3:0]   dig_uni, dig_dez, dig_cen;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: list of typed digits, overflow flag, committed flag.
    int           m_digits[$];
    logic         m_over;
    logic         m_done;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_out = '0;
    logic [3:0]   keys_q[$];

    io_entrada_teclado #(.DEBOUNCE_CYCLES(DEB), .DATA_W(W), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw), .req(req), .ack(ack),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .overflow(overflow),
        .bad_key(bad_key), .dig_uni(dig_uni), .dig_dez(dig_dez), .dig_cen(dig_cen),
        .press_pulse(press_pulse), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_value();
        logic [W-1:0] v = '0;
        foreach (m_digits[i]) v = v * 10 + W'(m_digits[i]);
        return v;
    endfunction

    function automatic logic [3:0] model_dig(input int pos);
        int n = m_digits.size();
        return (n > pos) ? 4'(m_digits[n-1-pos]) : 4'd0;
    endfunction

    task automatic model_commit();
        m_done = 1'b1;
        exp_q.push_back(model_value());
    endtask

    task automatic apply_model(input logic [3:0] key);
        if (m_done) return;
        if (key <= 4'd9) begin
            if (m_digits.size() < MAXD) begin
                m_digits.push_back(int'(key));
`ifdef IO_AUTO_COMMIT_EN
                if (m_digits.size() == MAXD) model_commit();
`endif
            end else begin
                m_over = 1'b1;
            end
        end else if (key == 4'hF) begin
            model_commit();
        end else if (key == 4'hE) begin
            m_digits.delete();
            m_over = 1'b0;
        end
    endtask

    // One full press/release of the button with the given switch code.
    task automatic press(input logic [3:0] key, output int n_press, output int n_bad,
                         output logic dv_after);
        int pulse_at;
        n_press = 0; n_bad = 0; dv_after = 1'b0; pulse_at = -1;
        sw_raw = key;
        repeat (3) @(negedge clk);
        btn_raw = 1'b1;
        for (int k = 1; k <= DEB + 10; k++) begin
            @(negedge clk);
            if (press_pulse) begin n_press++; pulse_at = k; end
            if (bad_key) n_bad++;
            if (pulse_at >= 0 && k == pulse_at + 1) dv_after = data_valid;
        end
        btn_raw = 1'b0;
        for (int k = 0; k < DEB + 6; k++) begin
            @(negedge clk);
            if (press_pulse) n_press++;
            if (bad_key) n_bad++;
        end
    endtask

    task automatic press_checked(input logic [3:0] key);
        int np, nb;
        logic dv;
        int exp_bad;
        press(key, np, nb, dv);
        apply_model(key);
        exp_bad = (key >= 4'd10 && key <= 4'd13) ? 1 : 0;
        n_vec++;
        if (np != 1) begin
            n_err++; $display("FAIL press_count key=%h got=%0d exp=1", key, np);
        end
        n_vec++;
        if (nb != exp_bad) begin
            n_err++; $display("FAIL bad_key key=%h got=%0d exp=%0d", key, nb, exp_bad);
        end
        n_vec++;
        if (dv !== m_done) begin
            n_err++; $display("FAIL valid_latency key=%h got=%b exp=%b", key, dv, m_done);
        end
    endtask

    task automatic start_entry();
        req = 1'b1;
        m_digits.delete(); m_over = 1'b0; m_done = 1'b0;
        @(negedge clk); @(negedge clk);
        // ack outside DONE must be ignored
        ack = 1'b1; @(negedge clk); ack = 1'b0; @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || dbg_state !== 2'd1) begin
            n_err++; $display("FAIL collect_entry busy=%b state=%0d exp busy=1 state=1", busy, dbg_state);
        end
    endtask

    task automatic finish_entry();
        logic [W-1:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL no_commit model never committed");
            exp = last_out;
        end else begin
            exp = exp_q.pop_front();
        end
        if (data_out !== exp || data_valid !== 1'b1) begin
            n_err++; $display("FAIL commit data_out=%0d valid=%b exp data_out=%0d valid=1", data_out, data_valid, exp);
        end
        n_vec++;
        if (overflow !== m_over || dig_uni !== model_dig(0) || dig_dez !== model_dig(1) || dig_cen !== model_dig(2)) begin
            n_err++;
            $display("FAIL digits ovf=%b cen/dez/uni=%0d/%0d/%0d exp ovf=%b %0d/%0d/%0d", overflow,
                     dig_cen, dig_dez, dig_uni, m_over, model_dig(2), model_dig(1), model_dig(0));
        end
        req = 1'b0;
        @(negedge clk); @(negedge clk);
        n_vec++;
        if (data_valid !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd2 || data_out !== exp) begin
            n_err++; $display("FAIL done_hold valid=%b busy=%b state=%0d exp valid=1 busy=0 state=2", data_valid, busy, dbg_state);
        end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        n_vec++;
        if (data_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL ack valid=%b state=%0d exp valid=0 state=0", data_valid, dbg_state);
        end
        last_out = exp;
        @(negedge clk);
    endtask

    task automatic run_entry();
        start_entry();
        foreach (keys_q[i]) press_checked(keys_q[i]);
        finish_entry();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (data_out !== '0 || data_valid || busy || overflow || bad_key || press_pulse ||
            dig_uni !== 0 || dig_dez !== 0 || dig_cen !== 0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL reset_state out=%0d valid=%b busy=%b state=%0d exp all 0", data_out, data_valid, busy, dbg_state);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_debounce();
        int n_pulses = 0;
        int pulse_at = -1;
        sw_raw = 4'd0;
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            repeat (2) begin
                @(negedge clk);
                if (press_pulse) n_pulses++;
            end
        end
        btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (press_pulse) begin n_pulses++; pulse_at = k; end
        end
        n_vec++;
        if (n_pulses != 1) begin
            n_err++; $display("FAIL debounce_count got=%0d exp=1", n_pulses);
        end
        n_vec++;
        if (pulse_at != 2 + DEB + 1) begin
            n_err++; $display("FAIL debounce_latency got=%0d exp=%0d", pulse_at, 2 + DEB + 1);
        end
        btn_raw = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic test_basic();
        keys_q = '{4'd1, 4'd2, 4'd3, 4'hF};
        run_entry();
    endtask

    task automatic test_overflow();
        keys_q = '{4'd9, 4'd9, 4'd9, 4'd4, 4'hF};
        run_entry();
    endtask

    task automatic test_clear_badkey();
        keys_q = '{4'd7, 4'hE, 4'd5, 4'hB, 4'hF};
        run_entry();
    endtask

    task automatic test_req_drop();
        start_entry();
        press_checked(4'd4);
        press_checked(4'd2);
        req = 1'b0;
        @(negedge clk); @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || dbg_state !== 2'd0 || data_out !== last_out) begin
            n_err++; $display("FAIL req_drop busy=%b state=%0d out=%0d exp busy=0 state=0 out=%0d", busy, dbg_state, data_out, last_out);
        end
        start_entry();
        press_checked(4'hF);
        finish_entry();
    endtask

    task automatic test_reset_mid_entry();
        start_entry();
        press_checked(4'd8);
        n_vec++;
        if (dig_uni !== 4'd8) begin
            n_err++; $display("FAIL pre_reset_digit got=%0d exp=8", dig_uni);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (data_out !== '0 || data_valid || busy || overflow || bad_key || press_pulse ||
            dig_uni !== 0 || dig_dez !== 0 || dig_cen !== 0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL reset_mid out=%0d busy=%b uni=%0d state=%0d exp all 0", data_out, busy, dig_uni, dbg_state);
        end
        @(negedge clk);
        reset = 1'b0;
        req = 1'b0;
        last_out = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int len, r;
        for (int e = 0; e < 6; e++) begin
            keys_q.delete();
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r == 7) keys_q.push_back(4'hE);
                else if (r == 8) keys_q.push_back(4'($urandom_range(10, 13)));
                else keys_q.push_back(4'($urandom_range(0, 9)));
            end
            keys_q.push_back(4'hF);
            run_entry();
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_basic();
        test_overflow();
        test_clear_badkey();
        test_req_drop();
        test_reset_mid_entry();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
